// File: rtl/conv_axis_out.sv
// conv_axis_out: output stage behind the 3x3 convolution core.
// Buffers the core's free-running pixel stream in a FIFO of {last, data}
// words. Buffered words leave through one output register as an AXI4-Stream
// master: tuser marks start of frame and tlast marks end of frame.
// Optional build macro CONV_AXIS_OUT_ALPHA_EN forces tdata[31:24] to 8'hFF
// on every output beat.
module conv_axis_out #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              overflow,
  output logic              frame_done,
  output logic [ADDR_W:0]   level
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              sof_pending;
  logic [DATA_W:0]   rd_word;
  logic [DATA_W-1:0] out_data;
  logic              full, empty, flush, wr_req, wr_en, rd_en;

  // Occupancy never exceeds DEPTH, so the top bit of level alone means full.
  assign full   = level[ADDR_W];
  assign empty  = (level == '0);
  // IDLE holds everything flushed; an abort flushes on the edge that leaves RUN/DRAIN.
  assign flush  = (state == S_IDLE) || (((state == S_RUN) || (state == S_DRAIN)) && !start);
  assign wr_req = (state == S_RUN) && start && in_valid;
  assign rd_en  = !flush && !empty && (!m_axis_tvalid || m_axis_tready);
  // When the FIFO is full, a write is accepted only if a read frees a slot in the same cycle.
  assign wr_en  = wr_req && (!full || rd_en);
  assign rd_word = mem[rd_ptr];

`ifdef CONV_AXIS_OUT_ALPHA_EN
  assign out_data = {8'hFF, rd_word[DATA_W-9:0]};
`else
  assign out_data = rd_word[DATA_W-1:0];
`endif

  // FIFO storage; no reset needed, the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_last, in_data};
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_en && !rd_en)      level <= level + (ADDR_W+1)'(1);
      else if (rd_en && !wr_en) level <= level - (ADDR_W+1)'(1);
    end
  end

  // AXIS output register: load on read, drop valid after the beat transfers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (flush) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (rd_en) begin
      m_axis_tdata  <= out_data;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= rd_word[DATA_W];
      m_axis_tuser  <= sof_pending;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end
  end

  // Sticky overflow: a word was lost to a full FIFO. Any start=0 clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      overflow <= 1'b0;
    else if (!start)                   overflow <= 1'b0;
    else if (wr_req && full && !rd_en) overflow <= 1'b1;
  end

  // Frame FSM, SOF tracking and frame_done pulse on DONE entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      sof_pending <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (rd_en) sof_pending <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state       <= S_RUN;
          sof_pending <= 1'b1;
        end
        S_RUN: begin
          // The last word moves to DRAIN whether it was written or dropped.
          if (!start)                    state <= S_IDLE;
          else if (in_valid && in_last)  state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!start) state <= S_IDLE;
          else if (empty && !m_axis_tvalid) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end
        end
        default: if (!start) state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_axis_out.sv
// Directed bench for conv_axis_out. A per-cycle vector table covers the
// nominal frame; hand-written sequences cover backpressure, full FIFO,
// overflow, abort, single-word frame and async reset.
module tb_conv_axis_out;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0, in_last = 1'b0, tready = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tuser, overflow, frame_done;
  logic [AW:0]   level;

  conv_axis_out #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .overflow(overflow), .frame_done(frame_done), .level(level)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0, fd_cnt = 0;

  typedef struct { logic [DW-1:0] d; logic l; logic u; } beat_t;
  beat_t beats[$];

  // Record transferred beats and frame_done pulses away from the active edge.
  always @(negedge clk) begin
    if (tvalid && tready) beats.push_back('{tdata, tlast, tuser});
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] xd(input logic [DW-1:0] d);
`ifdef CONV_AXIS_OUT_ALPHA_EN
    return {8'hFF, d[23:0]};
`else
    return d;
`endif
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
    in_valid = v; in_data = d; in_last = l;
  endtask

  task automatic wait_done(input int budget, input int fd0);
    int n = 0;
    while (fd_cnt == fd0 && n < budget) begin step(); n++; end
    chk("frame_done_seen", 64'(fd_cnt > fd0), 64'd1);
  endtask

  task automatic check_beats(input string nm, input int n, input logic [DW-1:0] base,
                             input logic last_end);
    chk({nm, "_count"}, 64'(beats.size()), 64'(n));
    for (int i = 0; i < n && i < beats.size(); i++) begin
      chk({nm, "_data"}, 64'(beats[i].d), 64'(xd(base + DW'(i))));
      chk({nm, "_user"}, 64'(beats[i].u), 64'(i == 0));
      chk({nm, "_last"}, 64'(beats[i].l), 64'(last_end && (i == n - 1)));
    end
  endtask

  typedef struct {
    logic v; logic [DW-1:0] d; logic l;
    logic tv; logic [DW-1:0] td; logic tl; logic tu; logic [AW:0] lv; logic fd;
  } vec_t;
  vec_t vt[10];

  initial begin
    int fd0;
    // Nominal frame, tready=1: inputs in cycle k, outputs observed in cycle k.
    vt[0] = '{1'b1, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 11'd0, 1'b0};
    vt[1] = '{1'b1, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 11'd1, 1'b0};
    vt[2] = '{1'b1, 32'd3, 1'b0, 1'b1, 32'd1, 1'b0, 1'b1, 11'd1, 1'b0};
    vt[3] = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 11'd1, 1'b0};
    vt[4] = '{1'b1, 32'd5, 1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 11'd1, 1'b0};
    vt[5] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd4, 1'b0, 1'b0, 11'd1, 1'b0};
    vt[6] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd5, 1'b1, 1'b0, 11'd0, 1'b0};
    vt[7] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 11'd0, 1'b0};
    vt[8] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 11'd0, 1'b1};
    vt[9] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 11'd0, 1'b0};

    // Reset state.
    step(); step();
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tuser", 64'(tuser), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    reset_n = 1'b1;
    step();

    // Nominal frame.
    beats.delete(); tready = 1'b1; start = 1'b1; step();
    for (int k = 0; k < 10; k++) begin
      drive(vt[k].v, vt[k].d, vt[k].l);
      chk("vec_tvalid", 64'(tvalid), 64'(vt[k].tv));
      if (vt[k].tv) begin
        chk("vec_tdata", 64'(tdata), 64'(xd(vt[k].td)));
        chk("vec_tlast", 64'(tlast), 64'(vt[k].tl));
        chk("vec_tuser", 64'(tuser), 64'(vt[k].tu));
      end
      chk("vec_level", 64'(level), 64'(vt[k].lv));
      chk("vec_frame_done", 64'(frame_done), 64'(vt[k].fd));
      chk("vec_overflow", 64'(overflow), 64'd0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    chk("nom_fd_count", 64'(fd_cnt), 64'd1);
    check_beats("nom", 5, 32'd1, 1'b1);
    start = 1'b0; step(); step();

    // Backpressure: first word parks in the output register, ten more queue up.
    beats.delete(); tready = 1'b0; start = 1'b1; step();
    for (int i = 0; i <= 10; i++) begin
      drive(1'b1, 32'h200 + DW'(i), i == 10);
      step();
      if (i >= 1) begin
        chk("bp_hold_tvalid", 64'(tvalid), 64'd1);
        chk("bp_hold_tdata", 64'(tdata), 64'(xd(32'h200)));
        chk("bp_hold_tuser", 64'(tuser), 64'd1);
      end
    end
    drive(1'b0, '0, 1'b0);
    chk("bp_level", 64'(level), 64'd10);
    fd0 = fd_cnt; tready = 1'b1;
    wait_done(100, fd0);
    check_beats("bp", 11, 32'h200, 1'b1);
    chk("bp_overflow", 64'(overflow), 64'd0);
    start = 1'b0; step(); step();

    // Full FIFO with simultaneous read and write: nothing lost.
    beats.delete(); tready = 1'b0; start = 1'b1; step();
    for (int i = 0; i <= 1024; i++) begin drive(1'b1, 32'h10000 + DW'(i), 1'b0); step(); end
    chk("full_level", 64'(level), 64'd1024);
    chk("full_tvalid", 64'(tvalid), 64'd1);
    chk("full_overflow", 64'(overflow), 64'd0);
    tready = 1'b1;
    for (int i = 1025; i <= 1028; i++) begin
      drive(1'b1, 32'h10000 + DW'(i), i == 1028); step();
      chk("rw_level", 64'(level), 64'd1024);
      chk("rw_overflow", 64'(overflow), 64'd0);
    end
    drive(1'b0, '0, 1'b0);
    fd0 = fd_cnt;
    wait_done(3000, fd0);
    check_beats("rw", 1029, 32'h10000, 1'b1);
    start = 1'b0; step(); step();

    // Overflow: one word in the output register plus 1024 queued; the final word is dropped.
    beats.delete(); tready = 1'b0; start = 1'b1; step();
    for (int i = 0; i <= 1025; i++) begin
      drive(1'b1, 32'h30000 + DW'(i), i == 1025); step();
      if (i == 1024) begin
        chk("ov_pre_level", 64'(level), 64'd1024);
        chk("ov_pre_flag", 64'(overflow), 64'd0);
      end
    end
    drive(1'b0, '0, 1'b0);
    chk("ov_flag", 64'(overflow), 64'd1);
    chk("ov_level", 64'(level), 64'd1024);
    repeat (5) step();
    chk("ov_sticky", 64'(overflow), 64'd1);
    fd0 = fd_cnt; tready = 1'b1;
    wait_done(3000, fd0);
    check_beats("ov", 1025, 32'h30000, 1'b0);
    chk("ov_after_drain", 64'(overflow), 64'd1);
    start = 1'b0; step();
    chk("ov_cleared", 64'(overflow), 64'd0);
    step();

    // Abort with 20 words queued and tready=0, then restart with a 3-word frame.
    beats.delete(); tready = 1'b0; start = 1'b1; step();
    for (int i = 0; i <= 20; i++) begin drive(1'b1, 32'h500 + DW'(i), 1'b0); step(); end
    drive(1'b0, '0, 1'b0);
    chk("ab_level", 64'(level), 64'd20);
    chk("ab_tvalid", 64'(tvalid), 64'd1);
    fd0 = fd_cnt; start = 1'b0; step();
    chk("ab_tvalid_drop", 64'(tvalid), 64'd0);
    chk("ab_level_clr", 64'(level), 64'd0);
    repeat (3) step();
    chk("ab_no_frame_done", 64'(fd_cnt), 64'(fd0));
    chk("ab_no_beats", 64'(beats.size()), 64'd0);
    tready = 1'b1; start = 1'b1; step();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 32'h600 + DW'(i), i == 2); step(); end
    drive(1'b0, '0, 1'b0);
    wait_done(50, fd0);
    check_beats("restart", 3, 32'h600, 1'b1);
    start = 1'b0; step(); step();

    // Single-word frame carries tuser and tlast together.
    beats.delete(); start = 1'b1; step();
    drive(1'b1, 32'h77, 1'b1); step(); drive(1'b0, '0, 1'b0);
    fd0 = fd_cnt;
    wait_done(50, fd0 - 1);
    repeat (4) step();
    check_beats("single", 1, 32'h77, 1'b1);
    start = 1'b0; step(); step();

    // Async reset between edges while a beat is presented.
    beats.delete(); tready = 1'b0; start = 1'b1; step();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 32'h900 + DW'(i), 1'b0); step(); end
    drive(1'b0, '0, 1'b0);
    chk("ar_tvalid_pre", 64'(tvalid), 64'd1);
    chk("ar_level_pre", 64'(level), 64'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_tvalid", 64'(tvalid), 64'd0);
    chk("ar_tuser", 64'(tuser), 64'd0);
    chk("ar_level", 64'(level), 64'd0);
    start = 1'b0; step(); step();
    reset_n = 1'b1; step();
    // Still IDLE: input is ignored.
    drive(1'b1, 32'hAA, 1'b0); step(); step(); drive(1'b0, '0, 1'b0);
    chk("ar_idle_level", 64'(level), 64'd0);
    chk("ar_idle_tvalid", 64'(tvalid), 64'd0);
    tready = 1'b1; start = 1'b1; step();
    fd0 = fd_cnt;
    drive(1'b1, 32'h12345678, 1'b1); step(); drive(1'b0, '0, 1'b0);
    wait_done(50, fd0);
    check_beats("ar_frame", 1, 32'h12345678, 1'b1);
    start = 1'b0; step(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
